// File: rtl/tl_async_a_source.sv
// tl_async_a_source: source end of a TileLink-UL A-channel async crossing (ring buffer + Gray write index).
// Optional TL_ASYNC_SOURCE_SAFE_EN adds index-valid handshakes so a sink reset clears this end.
module tl_async_a_source #(
    parameter int DEPTH = 8,
    parameter int SYNC = 3,
    localparam int IW = $clog2(DEPTH) + 1,
    localparam int EW = 86
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enq_valid,
    output logic               enq_ready,
    input  logic [2:0]         enq_opcode,
    input  logic [2:0]         enq_param,
    input  logic [1:0]         enq_size,
    input  logic [8:0]         enq_source,
    input  logic [31:0]        enq_address,
    input  logic [3:0]         enq_mask,
    input  logic [31:0]        enq_data,
    input  logic               enq_corrupt,
    output logic [DEPTH*EW-1:0] async_mem,
`ifdef TL_ASYNC_SOURCE_SAFE_EN
    output logic               async_widx_valid,
    input  logic               async_ridx_valid,
`endif
    output logic [IW-1:0]      async_widx,
    input  logic [IW-1:0]      async_ridx
);
    localparam logic [IW-1:0] FLIP = IW'(3) << (IW - 2);

    logic [IW-1:0] widxBin, widxNext, ridxS;
    (* ASYNC_REG = "TRUE" *) logic [IW-1:0] ridxSync [SYNC];
    logic full, fire, clr;

    always_comb begin
        widxNext = widxBin + IW'(1);
        ridxS = ridxSync[SYNC-1];
        full = async_widx == (ridxS ^ FLIP);
        fire = enq_valid && enq_ready;
    end

`ifdef TL_ASYNC_SOURCE_SAFE_EN
    logic rvS;
    (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] rvSync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvSync <= '0;
            async_widx_valid <= 1'b0;
        end else begin
            rvSync <= {rvSync[SYNC-2:0], async_ridx_valid};
            async_widx_valid <= 1'b1;
        end
    end

    // While the sink is held in reset, keep this end empty as well.
    always_comb begin
        rvS = rvSync[SYNC-1];
        clr = !rvS;
        enq_ready = !full && rvS;
    end
`else
    always_comb begin
        clr = 1'b0;
        enq_ready = !full;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clr) begin
            for (int i = 0; i < SYNC; i++) ridxSync[i] <= '0;
        end else begin
            ridxSync[0] <= async_ridx;
            for (int i = 1; i < SYNC; i++) ridxSync[i] <= ridxSync[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            widxBin <= '0;
            async_widx <= '0;
        end else if (clr) begin
            widxBin <= '0;
            async_widx <= '0;
        end else if (fire) begin
            widxBin <= widxNext;
            async_widx <= widxNext ^ (widxNext >> 1);
        end
    end

    // Storage is deliberately unreset; the index tells the sink what is valid.
    always_ff @(posedge clock) begin
        if (fire)
            async_mem[widxBin[IW-2:0]*EW +: EW] <= {enq_opcode, enq_param, enq_size, enq_source,
                                                   enq_address, enq_mask, enq_data, enq_corrupt};
    end
endmodule
